// File: rtl/nubus_master_burst_if.sv
// Bus-side and local-requester signals of the NuBus burst master, grouped for port use.
interface nubus_master_burst_if #(
  parameter int NCH    = 2,
  parameter int BEAT_W = 3
);
  logic                    nub_rqstn;
  logic                    nub_startn;
  logic                    nub_ackn;
  logic [1:0]              nub_tm;
  logic                    arb_grant;
  logic [NCH-1:0]          cpu_req;
  logic [NCH-1:0]          cpu_lock;
  logic [NCH*BEAT_W-1:0]   cpu_beats;
  logic [NCH-1:0]          cpu_gnt;
  logic                    cpu_done;
  logic [1:0]              cpu_status;
  logic [BEAT_W-1:0]       beat_o;
  logic                    arbcy_o;
  logic                    arbdn_o;
  logic                    adrcy_o;
  logic                    dtacy_o;
  logic                    owner_o;
  logic                    locked_o;
  logic                    busy_o;

  modport master (
    input  nub_rqstn, nub_startn, nub_ackn, nub_tm, arb_grant,
    input  cpu_req, cpu_lock, cpu_beats,
    output cpu_gnt, cpu_done, cpu_status, beat_o,
    output arbcy_o, arbdn_o, adrcy_o, dtacy_o, owner_o, locked_o, busy_o
  );

  modport slave (
    output nub_rqstn, nub_startn, nub_ackn, nub_tm, arb_grant,
    output cpu_req, cpu_lock, cpu_beats,
    input  cpu_gnt, cpu_done, cpu_status, beat_o,
    input  arbcy_o, arbdn_o, adrcy_o, dtacy_o, owner_o, locked_o, busy_o
  );
endinterface

// File: rtl/nubus_master_burst.sv
// NuBus master sequencer: fixed-priority channel select, arbitration, single/burst data
// phases with try-again retry, no-ack abort and optional locked NULL-ATN close.
module nubus_master_burst #(
  parameter int NCH       = 2,
  parameter int BEAT_W    = 3,
  parameter int TMO_W     = 8,
  parameter int TMO_MAX   = 255,
  parameter int RETRY_MAX = 3
) (
  input logic                  nub_clkn,
  input logic                  nub_reset,
  nubus_master_burst_if.master bus
);
  localparam int RTY_W = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);
  localparam logic [RTY_W-1:0] RTY_LIM = RTY_W'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ADDR, S_DATA, S_NULL, S_DONE
  } state_t;

  state_t              state, state_n;
  logic [NCH-1:0]      gnt, gnt_n;
  logic                lock_l, lock_n;
  logic [BEAT_W-1:0]   beats_l, beats_n;
  logic [BEAT_W-1:0]   beat, beat_n;
  logic [TMO_W-1:0]    tmo, tmo_n;
  logic [RTY_W-1:0]    retry, retry_n;
  logic [1:0]          status, status_n;
  logic                done, done_n;
  logic                arbcy, arbcy_n;
  logic                adrcy, adrcy_n;
  logic                dtacy, dtacy_n;
  logic                owner, owner_n;
  logic                locked, locked_n;
  logic                arbdn;
  logic                busy;

  logic                rqst, start, ack, win;
  logic                term;
  logic [1:0]          term_code;
  logic [NCH-1:0]      sel_gnt;
  logic                sel_lock;
  logic [BEAT_W-1:0]   sel_beats;

  assign rqst  = ~bus.nub_rqstn;
  assign start = ~bus.nub_startn;
  assign ack   = ~bus.nub_ackn;
  assign win   = arbcy & arbdn & bus.arb_grant & ((~busy & ~start) | (busy & ack));

  // Lowest index wins: scan from the top so the last hit is the highest priority.
  always_comb begin
    sel_gnt   = '0;
    sel_lock  = 1'b0;
    sel_beats = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.cpu_req[i]) begin
        sel_gnt    = '0;
        sel_gnt[i] = 1'b1;
        sel_lock   = bus.cpu_lock[i];
        sel_beats  = bus.cpu_beats[i*BEAT_W +: BEAT_W];
      end
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    lock_n    = lock_l;
    beats_n   = beats_l;
    beat_n    = beat;
    tmo_n     = tmo;
    retry_n   = retry;
    status_n  = status;
    done_n    = 1'b0;
    arbcy_n   = arbcy;
    adrcy_n   = 1'b0;
    dtacy_n   = dtacy;
    owner_n   = owner;
    locked_n  = locked;
    term      = 1'b0;
    term_code = 2'b00;

    unique case (state)
      S_IDLE: begin
        if (|bus.cpu_req && !rqst) begin
          gnt_n   = sel_gnt;
          lock_n  = sel_lock;
          beats_n = sel_beats;
          retry_n = '0;
          arbcy_n = 1'b1;
          state_n = S_ARB;
        end
      end
      S_ARB: begin
        if (win) begin
          owner_n  = 1'b1;
          locked_n = lock_l;
          adrcy_n  = 1'b1;
          arbcy_n  = lock_l;
          state_n  = S_ADDR;
        end
      end
      S_ADDR: begin
        dtacy_n = 1'b1;
        beat_n  = '0;
        tmo_n   = '0;
        state_n = S_DATA;
      end
      S_DATA: begin
        if (ack) begin
          unique case (bus.nub_tm)
            2'b00: begin
              if (beat == beats_l) begin
                term      = 1'b1;
                term_code = 2'b00;
              end else begin
                beat_n = beat + BEAT_W'(1);
                tmo_n  = '0;
              end
            end
            2'b11: begin
              if (retry < RTY_LIM) begin
                retry_n  = retry + RTY_W'(1);
                dtacy_n  = 1'b0;
                owner_n  = 1'b0;
                locked_n = 1'b0;
                arbcy_n  = 1'b1;
                state_n  = S_ARB;
              end else begin
                term      = 1'b1;
                term_code = 2'b11;
              end
            end
            default: begin
              term      = 1'b1;
              term_code = bus.nub_tm;
            end
          endcase
        end else if (tmo == TMO_LIM) begin
          term      = 1'b1;
          term_code = 2'b10;
        end else begin
          tmo_n = tmo + TMO_W'(1);
        end
      end
      S_NULL: begin
        locked_n = 1'b0;
        owner_n  = 1'b0;
        arbcy_n  = 1'b0;
        done_n   = 1'b1;
        state_n  = S_DONE;
      end
      S_DONE: begin
        gnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // A locked transaction is closed by a NULL-ATN start before reporting done.
    if (term) begin
      status_n = term_code;
      dtacy_n  = 1'b0;
      if (lock_l) begin
        adrcy_n = 1'b1;
        state_n = S_NULL;
      end else begin
        owner_n = 1'b0;
        done_n  = 1'b1;
        state_n = S_DONE;
      end
    end
  end

  always_ff @(posedge nub_clkn or posedge nub_reset) begin
    if (nub_reset) begin
      state   <= S_IDLE;
      gnt     <= '0;
      lock_l  <= 1'b0;
      beats_l <= '0;
      beat    <= '0;
      tmo     <= '0;
      retry   <= '0;
      status  <= 2'b00;
      done    <= 1'b0;
      arbcy   <= 1'b0;
      adrcy   <= 1'b0;
      dtacy   <= 1'b0;
      owner   <= 1'b0;
      locked  <= 1'b0;
      arbdn   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      lock_l  <= lock_n;
      beats_l <= beats_n;
      beat    <= beat_n;
      tmo     <= tmo_n;
      retry   <= retry_n;
      status  <= status_n;
      done    <= done_n;
      arbcy   <= arbcy_n;
      adrcy   <= adrcy_n;
      dtacy   <= dtacy_n;
      owner   <= owner_n;
      locked  <= locked_n;
      arbdn   <= arbcy & ~start;
      busy    <= (~busy & start & ~ack) | (busy & ~ack);
    end
  end

  assign bus.cpu_gnt    = gnt;
  assign bus.cpu_done   = done;
  assign bus.cpu_status = status;
  assign bus.beat_o     = beat;
  assign bus.arbcy_o    = arbcy;
  assign bus.arbdn_o    = arbdn;
  assign bus.adrcy_o    = adrcy;
  assign bus.dtacy_o    = dtacy;
  assign bus.owner_o    = owner;
  assign bus.locked_o   = locked;
  assign bus.busy_o     = busy;
endmodule

// File: tb/tb_nubus_master_burst.sv
// Randomized bench for nubus_master_burst with a transaction-level reference model.
module tb_nubus_master_burst;
  localparam int NCH       = 2;
  localparam int BEAT_W    = 3;
  localparam int TMO_MAX   = 255;
  localparam int RETRY_MAX = 3;
  localparam int SL        = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nubus_master_burst_if #(.NCH(NCH), .BEAT_W(BEAT_W)) bus ();

  nubus_master_burst #(
    .NCH(NCH), .BEAT_W(BEAT_W), .TMO_W(8), .TMO_MAX(TMO_MAX), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .nub_clkn (clk),
    .nub_reset(rst),
    .bus      (bus)
  );

  // Bus model: our own RQST/START loop back; the slave drives ACK, and a NULL-ATN
  // start (adrcy right after the data phase of a locked transfer) is an attention cycle.
  logic slave_ack = 1'b0;
  logic prev_dtacy;
  always @(posedge clk or posedge rst)
    if (rst) prev_dtacy <= 1'b0;
    else     prev_dtacy <= bus.dtacy_o;
  assign bus.nub_rqstn  = ~bus.arbcy_o;
  assign bus.nub_startn = ~bus.adrcy_o;
  assign bus.nub_ackn   = ~(slave_ack | (bus.adrcy_o & bus.locked_o & prev_dtacy));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("inv_adr_dt", 32'(bus.adrcy_o & bus.dtacy_o), 32'd0);
      chk("inv_owner", 32'((bus.adrcy_o | bus.dtacy_o) & ~bus.owner_o), 32'd0);
      chk("inv_gnt", 32'($onehot0(bus.cpu_gnt)), 32'd1);
    end
  end

  int sw [NCH][SL];
  int st [NCH][SL];
  int slen [NCH];
  int cfg_beats [NCH];
  bit cfg_lock [NCH];
  int exp_beat [SL];
  bit rand_grant = 1'b0;

  function automatic logic [31:0] all_outs();
    return 32'({bus.cpu_gnt, bus.cpu_done, bus.cpu_status, bus.beat_o, bus.arbcy_o,
                bus.arbdn_o, bus.adrcy_o, bus.dtacy_o, bus.owner_o, bus.locked_o, bus.busy_o});
  endfunction

  task automatic set_ch(input int ch, input int beats, input bit lock);
    cfg_beats[ch] = beats;
    cfg_lock[ch]  = lock;
    bus.cpu_beats[ch*BEAT_W +: BEAT_W] = BEAT_W'(beats);
    bus.cpu_lock[ch] = lock;
  endtask

  // Walk the ack script by the transaction rules: beat advance, retry, terminal codes.
  task automatic model(input int ch, output int status, output int arbs,
                       output int used, output bit tmo);
    int beat = 0;
    int retry = 0;
    bit fin = 1'b0;
    status = 0; arbs = 1; used = 0; tmo = 1'b0;
    while (!fin) begin
      if (used >= slen[ch]) begin
        status = 2; tmo = 1'b1; fin = 1'b1;
      end else begin
        exp_beat[used] = beat;
        case (st[ch][used])
          0: if (beat == cfg_beats[ch]) fin = 1'b1; else beat++;
          3: if (retry < RETRY_MAX) begin retry++; arbs++; beat = 0; end
             else begin status = 3; fin = 1'b1; end
          default: begin status = st[ch][used]; fin = 1'b1; end
        endcase
        used++;
      end
    end
  endtask

  task automatic serve(input int ch, input string tag, output int lat);
    int m_status, m_arbs, m_used, exp_dtc;
    bit m_tmo;
    int cyc = 0, idx = 0, wcnt = 0, adr = 0, dtc = 0, own = 0, lck = 0, arbbad = 0;
    bit done = 1'b0;
    logic prev_adr = 1'b0;
    model(ch, m_status, m_arbs, m_used, m_tmo);
    exp_dtc = m_tmo ? TMO_MAX + 1 : 0;
    for (int i = 0; i < m_used; i++) exp_dtc += sw[ch][i] + 1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_done) begin
        done = 1'b1;
        slave_ack = 1'b0;
        chk({tag, "_status"}, 32'(bus.cpu_status), 32'(m_status));
        chk({tag, "_gnt"}, 32'(bus.cpu_gnt), 32'(1) << ch);
        chk({tag, "_adrcy_cnt"}, 32'(adr), 32'(m_arbs + int'(cfg_lock[ch])));
        chk({tag, "_acks"}, 32'(idx), 32'(m_used));
        chk({tag, "_dtacy_cnt"}, 32'(dtc), 32'(exp_dtc));
        chk({tag, "_locked_cnt"}, 32'(lck), cfg_lock[ch] ? 32'(own) : 32'd0);
        chk({tag, "_arbcy_hold"}, 32'(arbbad), 32'd0);
        chk({tag, "_done_after_null"}, 32'(prev_adr), 32'(cfg_lock[ch]));
        bus.cpu_req[ch] = 1'b0;
      end else begin
        if (bus.adrcy_o)  adr++;
        if (bus.dtacy_o)  dtc++;
        if (bus.owner_o)  own++;
        if (bus.locked_o) lck++;
        if (bus.dtacy_o && (bus.arbcy_o != cfg_lock[ch])) arbbad++;
        prev_adr = bus.adrcy_o;
        if (rand_grant) bus.arb_grant = ($urandom_range(0, 3) != 0);
        slave_ack = 1'b0;
        if (bus.dtacy_o) begin
          if (idx < slen[ch] && wcnt == sw[ch][idx]) begin
            slave_ack  = 1'b1;
            bus.nub_tm = 2'(st[ch][idx]);
            chk({tag, "_beat"}, 32'(bus.beat_o), 32'(exp_beat[idx]));
            idx++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
    if (!done) chk({tag, "_no_done"}, 32'd0, 32'd1);
    lat = cyc;
  endtask

  initial begin
    int lat, n, mask;
    bus.cpu_req   = '0;
    bus.cpu_lock  = '0;
    bus.cpu_beats = '0;
    bus.nub_tm    = 2'b00;
    bus.arb_grant = 1'b1;
    #1;
    chk("reset_outs", all_outs(), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single beat, two wait cycles, grant at once.
    set_ch(0, 0, 1'b0);
    slen[0] = 1; sw[0][0] = 2; st[0][0] = 0;
    bus.cpu_req[0] = 1'b1;
    serve(0, "t1", lat);
    chk("t1_latency", 32'(lat), 32'd7);

    // Simultaneous requests: ch0 first, then ch1 without re-request.
    set_ch(0, 1, 1'b0); slen[0] = 2; sw[0][0] = 0; st[0][0] = 0; sw[0][1] = 1; st[0][1] = 0;
    set_ch(1, 0, 1'b0); slen[1] = 1; sw[1][0] = 1; st[1][0] = 1;
    bus.cpu_req = 2'b11;
    serve(0, "t2a", lat);
    serve(1, "t2b", lat);

    // Four-beat burst.
    set_ch(0, 3, 1'b0); slen[0] = 4;
    for (int i = 0; i < 4; i++) begin sw[0][i] = i & 1; st[0][i] = 0; end
    bus.cpu_req[0] = 1'b1;
    serve(0, "t3", lat);
    @(negedge clk);
    chk("t3_single_done", 32'(bus.cpu_done), 32'd0);

    // Locked single beat closed by NULL-ATN.
    set_ch(1, 0, 1'b1); slen[1] = 1; sw[1][0] = 1; st[1][0] = 0;
    bus.cpu_req[1] = 1'b1;
    serve(1, "t4", lat);

    // Try-again exhaustion, then no-ack abort.
    set_ch(0, 0, 1'b0); slen[0] = 4;
    for (int i = 0; i < 4; i++) begin sw[0][i] = 0; st[0][i] = 3; end
    bus.cpu_req[0] = 1'b1;
    serve(0, "t5a", lat);
    slen[0] = 0;
    bus.cpu_req[0] = 1'b1;
    serve(0, "t5b", lat);
    chk("t5_busy_held", 32'(bus.busy_o), 32'd1);
    slave_ack = 1'b1; bus.nub_tm = 2'b10;
    @(negedge clk);
    slave_ack = 1'b0;
    @(negedge clk);
    chk("t5_busy_clear", 32'(bus.busy_o), 32'd0);

    // Asynchronous reset in the middle of a data phase.
    set_ch(0, 3, 1'b0);
    bus.cpu_req[0] = 1'b1;
    n = 0;
    while (!bus.dtacy_o && n < 50) begin @(negedge clk); n++; end
    chk("t6_reach_data", 32'(bus.dtacy_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_req = '0;
    #1;
    chk("t6_outs_zero", all_outs(), 32'd0);
    @(negedge clk);
    chk("t6_no_done", 32'(bus.cpu_done), 32'd0);
    rst = 1'b0;
    set_ch(1, 1, 1'b1); slen[1] = 2; sw[1][0] = 0; st[1][0] = 0; sw[1][1] = 2; st[1][1] = 0;
    bus.cpu_req[1] = 1'b1;
    serve(1, "t6_fresh", lat);

    // Randomized transactions with random grant delays.
    rand_grant = 1'b1;
    for (int t = 0; t < 30; t++) begin
      mask = $urandom_range(1, 3);
      for (int ch = 0; ch < NCH; ch++) begin
        set_ch(ch, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        slen[ch] = SL;
        for (int i = 0; i < SL; i++) begin
          int r;
          r = $urandom_range(0, 9);
          sw[ch][i] = $urandom_range(0, 3);
          st[ch][i] = (r < 6) ? 0 : (r < 8) ? 3 : (r == 8) ? 1 : 2;
        end
      end
      bus.cpu_req = 2'(mask);
      for (int ch = 0; ch < NCH; ch++)
        if (mask[ch]) serve(ch, "rnd", lat);
    end
    rand_grant = 1'b0;
    bus.arb_grant = 1'b1;

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
